// File: rtl/alu_pkg.sv
// alu_pkg: ALUOp encodings and scheduler FSM state encoding shared by alu_req_sched and its bench.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with combinational grant and a registered last-grant pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_q, last_d;

    // On a conflict the port that did not win last time is served; a lone request always wins.
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (en) begin
            if (valid == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
        if (grant[0]) begin
            last_d = 1'b0;
        end else if (grant[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// alu_req_sched: shares one ALU between two valid/ready issue ports, one tagged response per request.
// Optional macro ALU_SCHED_TIMEOUT_EN aborts an EXEC that waits TIMEOUT_CYCLES for alu_we.
module alu_req_sched
    import alu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_we,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_c,
    output logic             rsp_err
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_c_q, rsp_c_d;
    logic [1:0]       grant;
    logic             arb_en;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    // Grants are only offered while idle and never during the reset cycle.
    assign arb_en = (state_q == S_IDLE) && !Reset;

    rr_arb2 u_arb (
        .clk   (Clk),
        .reset (Reset),
        .en    (arb_en),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_c_d      = rsp_c_q;
`ifdef ALU_SCHED_TIMEOUT_EN
        tmo_d        = tmo_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    alu_a_d  = grant[1] ? req1_A  : req0_A;
                    alu_b_d  = grant[1] ? req1_B  : req0_B;
                    alu_op_d = grant[1] ? req1_op : req0_op;
                    rsp_id_d = grant[1];
                    state_d  = S_EXEC;
`ifdef ALU_SCHED_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
            end
            // Dropping alu_op back to AND on completion releases the ALU mod unit so every MOD restarts cleanly.
            S_EXEC: begin
                if (alu_we) begin
                    rsp_result_d = alu_result;
                    rsp_c_d      = alu_c;
                    alu_op_d     = OP_AND;
                    state_d      = S_RESP;
`ifdef ALU_SCHED_TIMEOUT_EN
                    rsp_err_d    = 1'b0;
                end else begin
                    if (tmo_q != TMO_LIMIT) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                    if (tmo_d == TMO_LIMIT) begin
                        rsp_result_d = '0;
                        rsp_c_d      = 1'b0;
                        rsp_err_d    = 1'b1;
                        alu_op_d     = OP_AND;
                        state_d      = S_RESP;
                    end
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_AND;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_c_q      <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
            tmo_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_c_q      <= rsp_c_d;
`ifdef ALU_SCHED_TIMEOUT_EN
            tmo_q        <= tmo_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_c      = rsp_c_q;
`ifdef ALU_SCHED_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule
